// File: rtl/model_state_gate_vector_backward_pkg.sv
// Shared encoding, Q-format constants and saturating helpers for the
// LSTM state-gate backward datapath.
package model_state_gate_vector_backward_pkg;

    localparam int DATA_W = 64;
    localparam int FRAC_W = 32;

    localparam logic [2:0] STARTER = 3'd0;
    localparam logic [2:0] INPUT   = 3'd1;
    localparam logic [2:0] MULT1   = 3'd2;
    localparam logic [2:0] MULT2   = 3'd3;
    localparam logic [2:0] ADD     = 3'd4;
    localparam logic [2:0] OUTPUT  = 3'd5;

    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [DATA_W-1:0] MAX_DATA  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_DATA  = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] one_q(input int frac);
        return {{(DATA_W-1){1'b0}}, 1'b1} << frac;
    endfunction

    function automatic logic signed [2*DATA_W-1:0] truncate_q(
        input logic signed [2*DATA_W-1:0] p,
        input int                         frac
    );
        return p >>> frac;
    endfunction

    // Clamp a double-width value: in range only if the top DATA_W+1 bits agree.
    function automatic logic [DATA_W-1:0] saturate_wide(
        input logic signed [2*DATA_W-1:0] x
    );
        if (x[2*DATA_W-1:DATA_W-1] == {(DATA_W+1){x[2*DATA_W-1]}})
            return x[DATA_W-1:0];
        else if (x[2*DATA_W-1])
            return MIN_DATA;
        else
            return MAX_DATA;
    endfunction

    function automatic logic [DATA_W-1:0] saturate_sum(
        input logic signed [DATA_W:0] x
    );
        if (x[DATA_W] == x[DATA_W-1])
            return x[DATA_W-1:0];
        else if (x[DATA_W])
            return MIN_DATA;
        else
            return MAX_DATA;
    endfunction

endpackage

// File: rtl/model_state_gate_vector_backward_multiplier.sv
// Combinational signed Q-format multiply with floor truncation and
// saturation back to the operand width.
module model_fixed_multiplier
    import model_state_gate_vector_backward_pkg::*;
#(
    parameter int DATA_SIZE = DATA_W,
    parameter int FRAC_SIZE = FRAC_W
) (
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    logic signed [2*DATA_SIZE-1:0] a_ext;
    logic signed [2*DATA_SIZE-1:0] b_ext;
    logic signed [2*DATA_SIZE-1:0] product;

    assign a_ext   = {{DATA_SIZE{DATA_A_IN[DATA_SIZE-1]}}, DATA_A_IN};
    assign b_ext   = {{DATA_SIZE{DATA_B_IN[DATA_SIZE-1]}}, DATA_B_IN};
    assign product = a_ext * b_ext;

    assign DATA_OUT = saturate_wide(truncate_q(product, FRAC_SIZE));

endmodule

// File: rtl/model_state_gate_vector_backward.sv
// Streams ds(t) = dh o o o (1 - tanh^2 s) + ds(t+1) o f(t+1) element by
// element over a layer vector of length L.
module model_state_gate_vector_backward
    import model_state_gate_vector_backward_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_W,
    parameter int FRAC_SIZE    = FRAC_W,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DH_IN_ENABLE,
    input  logic                 O_IN_ENABLE,
    input  logic                 T_IN_ENABLE,
    input  logic                 F_IN_ENABLE,
    input  logic                 DS_IN_ENABLE,
    output logic                 DH_OUT_ENABLE,
    output logic                 O_OUT_ENABLE,
    output logic                 T_OUT_ENABLE,
    output logic                 F_OUT_ENABLE,
    output logic                 DS_OUT_ENABLE,
    output logic                 DS_VALID,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    input  logic [DATA_SIZE-1:0] DH_IN,
    input  logic [DATA_SIZE-1:0] O_IN,
    input  logic [DATA_SIZE-1:0] T_IN,
    input  logic [DATA_SIZE-1:0] F_IN,
    input  logic [DATA_SIZE-1:0] DS_IN,
    output logic [DATA_SIZE-1:0] DS_OUT
);

    localparam logic [DATA_SIZE-1:0] ONE_Q = one_q(FRAC_SIZE);

    logic [2:0]           state;
    logic                 req;
    logic [4:0]           flags;
    logic [4:0]           strobes;
    logic [4:0]           flags_next;
    logic [DATA_SIZE-1:0] size_l, index;
    logic [DATA_SIZE-1:0] dh_q, o_q, t_q, f_q, dsn_q;
    logic [DATA_SIZE-1:0] p1, p2, p3, p4;
    logic [DATA_SIZE-1:0] mul_a_x, mul_a_y, mul_a_p;
    logic [DATA_SIZE-1:0] mul_b_x, mul_b_y, mul_b_p;
    logic [DATA_SIZE-1:0] one_minus_p2, ds_sum;
    logic                 last;

    assign strobes    = {DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE,
                         F_IN_ENABLE, DS_IN_ENABLE};
    assign flags_next = flags | strobes;
    assign last       = (index == size_l - DATA_SIZE'(1));

    assign one_minus_p2 = saturate_sum({ONE_Q[DATA_SIZE-1], ONE_Q}
                                     - {p2[DATA_SIZE-1], p2});
    assign ds_sum       = saturate_sum({p3[DATA_SIZE-1], p3}
                                     + {p4[DATA_SIZE-1], p4});

    // Each multiplier is shared between the two MULT states.
    assign mul_a_x = (state == MULT1) ? dh_q : p1;
    assign mul_a_y = (state == MULT1) ? o_q  : one_minus_p2;
    assign mul_b_x = (state == MULT1) ? t_q  : dsn_q;
    assign mul_b_y = (state == MULT1) ? t_q  : f_q;

    model_fixed_multiplier #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_SIZE (FRAC_SIZE)
    ) u_mul_a (
        .DATA_A_IN (mul_a_x),
        .DATA_B_IN (mul_a_y),
        .DATA_OUT  (mul_a_p)
    );

    model_fixed_multiplier #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_SIZE (FRAC_SIZE)
    ) u_mul_b (
        .DATA_A_IN (mul_b_x),
        .DATA_B_IN (mul_b_y),
        .DATA_OUT  (mul_b_p)
    );

    assign DH_OUT_ENABLE = req;
    assign O_OUT_ENABLE  = req;
    assign T_OUT_ENABLE  = req;
    assign F_OUT_ENABLE  = req;
    assign DS_OUT_ENABLE = req;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= STARTER;
            READY    <= 1'b0;
            DS_VALID <= 1'b0;
            DS_OUT   <= ZERO_DATA;
            req      <= 1'b0;
            flags    <= '0;
            size_l   <= ZERO_DATA;
            index    <= ZERO_DATA;
            dh_q     <= ZERO_DATA;
            o_q      <= ZERO_DATA;
            t_q      <= ZERO_DATA;
            f_q      <= ZERO_DATA;
            dsn_q    <= ZERO_DATA;
            p1       <= ZERO_DATA;
            p2       <= ZERO_DATA;
            p3       <= ZERO_DATA;
            p4       <= ZERO_DATA;
        end else begin
            READY    <= 1'b0;
            DS_VALID <= 1'b0;
            req      <= 1'b0;
            unique case (state)
                STARTER: begin
                    if (START) begin
                        size_l <= SIZE_L_IN;
                        index  <= ZERO_DATA;
                        if (SIZE_L_IN == ZERO_DATA) begin
                            READY <= 1'b1;
                        end else begin
                            req   <= 1'b1;
                            state <= INPUT;
                        end
                    end
                end
                INPUT: begin
                    if (DH_IN_ENABLE) dh_q  <= DH_IN;
                    if (O_IN_ENABLE)  o_q   <= O_IN;
                    if (T_IN_ENABLE)  t_q   <= T_IN;
                    if (F_IN_ENABLE)  f_q   <= F_IN;
                    if (DS_IN_ENABLE) dsn_q <= DS_IN;
                    flags <= flags_next;
                    if (&flags_next) state <= MULT1;
                end
                MULT1: begin
                    p1    <= mul_a_p;
                    p2    <= mul_b_p;
                    state <= MULT2;
                end
                MULT2: begin
                    p3    <= mul_a_p;
                    p4    <= mul_b_p;
                    state <= ADD;
                end
                // Result, strobe and next request all land in the OUTPUT cycle.
                ADD: begin
                    DS_OUT   <= ds_sum;
                    DS_VALID <= 1'b1;
                    flags    <= '0;
                    if (last) begin
                        READY <= 1'b1;
                    end else begin
                        index <= index + DATA_SIZE'(1);
                        req   <= 1'b1;
                    end
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    state <= READY ? STARTER : INPUT;
                end
                default: begin
                    state <= STARTER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_model_state_gate_vector_backward.sv
// Directed checks of the state-gate backward stream: timing, ordering,
// saturation, L=0, ignored inputs and mid-pass reset.
module tb_model_state_gate_vector_backward;

    localparam logic [63:0] Q_ONE  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] Q_HALF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] Q_QTR  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] Q_TWO  = 64'h0000_0002_0000_0000;
    localparam logic [63:0] Q_THR  = 64'h0000_0003_0000_0000;
    localparam logic [63:0] Q_M1   = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] Q_M2   = 64'hFFFF_FFFE_0000_0000;
    localparam logic [63:0] Q_BIG  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] Q_NBIG = 64'hC000_0000_0000_0000;

    logic        CLK, RST, START, READY, DS_VALID;
    logic        DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE;
    logic        F_IN_ENABLE, DS_IN_ENABLE;
    logic        DH_OUT_ENABLE, O_OUT_ENABLE, T_OUT_ENABLE;
    logic        F_OUT_ENABLE, DS_OUT_ENABLE;
    logic [63:0] SIZE_L_IN, DH_IN, O_IN, T_IN, F_IN, DS_IN, DS_OUT;
    logic [4:0]  req_obs;

    int n_cmp;
    int n_bad;

    model_state_gate_vector_backward dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .READY         (READY),
        .DH_IN_ENABLE  (DH_IN_ENABLE),
        .O_IN_ENABLE   (O_IN_ENABLE),
        .T_IN_ENABLE   (T_IN_ENABLE),
        .F_IN_ENABLE   (F_IN_ENABLE),
        .DS_IN_ENABLE  (DS_IN_ENABLE),
        .DH_OUT_ENABLE (DH_OUT_ENABLE),
        .O_OUT_ENABLE  (O_OUT_ENABLE),
        .T_OUT_ENABLE  (T_OUT_ENABLE),
        .F_OUT_ENABLE  (F_OUT_ENABLE),
        .DS_OUT_ENABLE (DS_OUT_ENABLE),
        .DS_VALID      (DS_VALID),
        .SIZE_L_IN     (SIZE_L_IN),
        .DH_IN         (DH_IN),
        .O_IN          (O_IN),
        .T_IN          (T_IN),
        .F_IN          (F_IN),
        .DS_IN         (DS_IN),
        .DS_OUT        (DS_OUT)
    );

    assign req_obs = {DH_OUT_ENABLE, O_OUT_ENABLE, T_OUT_ENABLE,
                      F_OUT_ENABLE, DS_OUT_ENABLE};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One strobe cycle for the operands selected by m = {dh,o,t,f,ds}.
    task automatic send(input logic [4:0] m, input logic [63:0] dh,
                        input logic [63:0] o, input logic [63:0] t,
                        input logic [63:0] f, input logic [63:0] ds);
        {DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE,
         F_IN_ENABLE, DS_IN_ENABLE} = m;
        DH_IN = dh; O_IN = o; T_IN = t; F_IN = f; DS_IN = ds;
        tick();
        {DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE,
         F_IN_ENABLE, DS_IN_ENABLE} = 5'b0;
    endtask

    task automatic begin_pass(input string tag, input logic [63:0] len);
        SIZE_L_IN = len;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk({tag, "_req0"}, 64'(req_obs), 64'h1F);
        tick();
    endtask

    // Called right after the final strobe; lands on the DS_VALID cycle.
    task automatic expect_out(input string tag, input logic [63:0] ds,
                              input logic rdy);
        tick();
        tick();
        tick();
        chk({tag, "_valid"}, 64'(DS_VALID), 64'd1);
        chk({tag, "_ds"}, DS_OUT, ds);
        chk({tag, "_ready"}, 64'(READY), 64'(rdy));
        chk({tag, "_req"}, 64'(req_obs), rdy ? 64'h0 : 64'h1F);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        START = 1'b0;
        SIZE_L_IN = '0;
        {DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE,
         F_IN_ENABLE, DS_IN_ENABLE} = 5'b0;
        DH_IN = '0; O_IN = '0; T_IN = '0; F_IN = '0; DS_IN = '0;
        tick();
        tick();
        chk("rst_ready", 64'(READY), 64'd0);
        chk("rst_valid", 64'(DS_VALID), 64'd0);
        chk("rst_ds", DS_OUT, 64'd0);
        chk("rst_req", 64'(req_obs), 64'd0);
        RST = 1'b0;
        tick();

        // Single element, zero-wait producers.
        begin_pass("s1", 64'd1);
        send(5'b11111, Q_ONE, Q_HALF, Q_HALF, Q_QTR, Q_TWO);
        expect_out("s1", 64'h0000_0000_E000_0000, 1'b1);
        chk("s1_valid_drop", 64'(DS_VALID), 64'd0);
        chk("s1_ready_drop", 64'(READY), 64'd0);

        // L=3, scattered and simultaneous arrivals.
        begin_pass("s2", 64'd3);
        send(5'b00010, '0, '0, '0, '0, '0);
        send(5'b00001, '0, '0, '0, '0, '0);
        send(5'b00100, '0, '0, '0, '0, '0);
        send(5'b01000, '0, Q_ONE, '0, '0, '0);
        tick();
        tick();
        chk("s2_hold_valid", 64'(DS_VALID), 64'd0);
        chk("s2_hold_req", 64'(req_obs), 64'd0);
        send(5'b10000, Q_ONE, '0, '0, '0, '0);
        expect_out("s2e0", Q_ONE, 1'b0);
        send(5'b00110, '0, '0, Q_ONE, Q_HALF, '0);
        send(5'b11001, Q_TWO, Q_HALF, '0, '0, Q_THR);
        expect_out("s2e1", 64'h0000_0001_8000_0000, 1'b0);
        send(5'b00010, '0, '0, '0, Q_QTR, '0);
        send(5'b01000, '0, 64'h1234_5678_9ABC_DEF0, '0, '0, '0);
        send(5'b00001, '0, '0, '0, '0, Q_M2);
        send(5'b00100, '0, '0, Q_HALF, '0, '0);
        send(5'b01000, '0, Q_HALF, '0, '0, '0);
        send(5'b10000, Q_M1, '0, '0, '0, '0);
        expect_out("s2e2", 64'hFFFF_FFFF_2000_0000, 1'b1);
        chk("s2_ready_drop", 64'(READY), 64'd0);

        // Saturation, both signs.
        begin_pass("s3", 64'd2);
        send(5'b11111, Q_BIG, Q_BIG, '0, '0, '0);
        expect_out("s3pos", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(5'b11111, Q_NBIG, Q_BIG, '0, '0, '0);
        expect_out("s3neg", 64'h8000_0000_0000_0000, 1'b1);

        // Empty vector.
        SIZE_L_IN = 64'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("s4_l0_ready", 64'(READY), 64'd1);
        chk("s4_l0_req", 64'(req_obs), 64'd0);
        tick();
        chk("s4_l0_valid", 64'(DS_VALID), 64'd0);
        chk("s4_l0_ready_drop", 64'(READY), 64'd0);

        // START pulses mid-pass must not restart or shorten an L=4 pass.
        begin_pass("s4", 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                SIZE_L_IN = 64'd1;
                START = 1'b1;
            end
            send(5'b11111, Q_ONE, Q_ONE, '0, '0, '0);
            START = 1'b0;
            if (i == 1) START = 1'b1;
            tick();
            START = 1'b0;
            tick();
            tick();
            chk($sformatf("s4e%0d_valid", i), 64'(DS_VALID), 64'd1);
            chk($sformatf("s4e%0d_ds", i), DS_OUT, Q_ONE);
            chk($sformatf("s4e%0d_ready", i), 64'(READY),
                (i == 3) ? 64'd1 : 64'd0);
            tick();
        end

        // Reset while element 2 sits in MULT2.
        begin_pass("s5", 64'd3);
        send(5'b11111, Q_ONE, Q_ONE, '0, '0, '0);
        expect_out("s5e0", Q_ONE, 1'b0);
        send(5'b11111, Q_TWO, Q_HALF, Q_ONE, Q_HALF, Q_THR);
        expect_out("s5e1", 64'h0000_0001_8000_0000, 1'b0);
        send(5'b11111, Q_ONE, Q_HALF, Q_HALF, Q_QTR, Q_TWO);
        tick();
        RST = 1'b1;
        #1;
        chk("s5_rst_ds", DS_OUT, 64'd0);
        chk("s5_rst_valid", 64'(DS_VALID), 64'd0);
        chk("s5_rst_ready", 64'(READY), 64'd0);
        chk("s5_rst_req", 64'(req_obs), 64'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("s5_quiet%0d", i),
                64'({READY, DS_VALID, req_obs}), 64'd0);
        end
        begin_pass("s5b", 64'd1);
        send(5'b11111, Q_ONE, Q_HALF, Q_HALF, Q_QTR, Q_TWO);
        expect_out("s5b", 64'h0000_0000_E000_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/model_state_gate_vector_backward.md
# model_state_gate_vector_backward

Backward-pass counterpart of the LSTM forward state-gate vector in the convolutional controller. It streams element by element over one layer vector of length L and computes the state gradient ds(t;l) = dh(t;l) o o(t;l) o (1 - tanh²(s(t;l))) + ds(t+1;l) o f(t+1;l). It requests each operand element with an OUT_ENABLE pulse, captures operands on their IN_ENABLE strobes, and emits one gradient element per request round. It sits between the hidden-gate backward block and the forget/input/activation gradient blocks; tanh(s) arrives precomputed from the forward trace.

## Interface
- DATA_SIZE, 64, operand/result width; signed fixed point.
- FRAC_SIZE, 32, fractional bits; ONE = 1 << FRAC_SIZE.
- CONTROL_SIZE, 4, kept for family compatibility; unused internally.

- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begins a vector pass.
- READY  out  1  one-cycle pulse when the pass completes.
- DH_IN_ENABLE, O_IN_ENABLE, T_IN_ENABLE, F_IN_ENABLE, DS_IN_ENABLE  in  1 each  operand strobes: dh(t), o(t), tanh(s(t)), f(t+1), ds(t+1).
- DH_OUT_ENABLE, O_OUT_ENABLE, T_OUT_ENABLE, F_OUT_ENABLE, DS_OUT_ENABLE  out  1 each  one-cycle element requests to the producers.
- DS_VALID  out  1  one-cycle strobe; DS_OUT holds a valid element.
- SIZE_L_IN  in  DATA_SIZE  vector length L, unsigned; sampled at START.
- DH_IN, O_IN, T_IN, F_IN, DS_IN  in  DATA_SIZE each  operand data, valid with the matching strobe.
- DS_OUT  out  DATA_SIZE  gradient element ds(t;l).

## Operation
- Reset values: READY 0, DS_VALID 0, all *_OUT_ENABLE 0, DS_OUT 0, FSM in STARTER, index 0, all operand-captured flags clear.
- States:
  - STARTER: wait for START; latch SIZE_L_IN; clear index. L = 0 -> READY pulse next cycle, return to STARTER. Otherwise go to INPUT and pulse all five OUT_ENABLEs.
  - INPUT: each *_IN_ENABLE captures its operand and sets its flag. Operands may arrive in any order, the same cycle, or across many cycles. A repeat strobe for an already-captured operand overwrites it. Go to MULT1 once all five flags are set, counting strobes in the current cycle.
  - MULT1: p1 = dh*o; p2 = t*t.
  - MULT2: p3 = p1*(ONE - p2); p4 = ds_next*f.
  - ADD: ds = p3 + p4.
  - OUTPUT: DS_OUT <= ds; DS_VALID pulses; flags clear.
    - index == L-1 -> READY pulses, go to STARTER.
    - Otherwise index++, all OUT_ENABLEs pulse, go to INPUT.
- Arithmetic:
  - Multiply: full 2*DATA_SIZE signed product, arithmetic shift right by FRAC_SIZE (truncation toward -inf), then saturate to DATA_SIZE.
  - Add/subtract: DATA_SIZE+1 bits, then saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- Strobes outside INPUT are ignored. START outside STARTER is ignored.
- RST mid-pass aborts immediately to reset values; no READY and no partial DS_VALID.

## Timing
- START at cycle 0 -> OUT_ENABLEs pulse at cycle 1 (element 0 request).
- Last operand strobe at cycle k -> MULT1 at k+1, MULT2 at k+2, ADD at k+3, DS_VALID high at k+4.
- The next element's request pulses in the same cycle as DS_VALID (k+4). For the last element, READY pulses in that cycle instead.
- With zero-wait producers (strobe in the cycle after the request), throughput is one element per 5 cycles. An L=N pass takes 5N cycles after START.

## Structure
- Shared package model_state_gate_vector_backward_pkg holds:
  - the state encoding STARTER, INPUT, MULT1, MULT2, ADD, OUTPUT (3-bit);
  - the ZERO_DATA and ONE constants as functions of FRAC_SIZE;
  - saturate/truncate helper functions.
- One sub-module: model_fixed_multiplier (combinational signed Q multiply, truncate, saturate), instantiated twice so each MULT state completes in one cycle.

## Test plan
- Use FRAC_SIZE=32 for all scenarios.
- Single element: L=1, dh=1.0, o=0.5, t=0.5, ds_next=2.0, f=0.25 -> DS_OUT=0.875 (0x00000000E0000000). DS_VALID and READY both pulse 4 cycles after the last strobe.
- Out-of-order/simultaneous arrival: L=3; strobes scattered (F first, DH last), with two operands in the same cycle for element 1 -> three correct DS_VALID pulses, index advances only when all five are captured, one READY.
- Saturation: dh=o=2^30, t=0, ds_next=f=0 -> DS_OUT=0x7FFFFFFFFFFFFFFF. Negative mirror case -> 0x8000000000000000.
- L=0 and ignored inputs: START with L=0 -> READY one cycle later, no OUT_ENABLE or DS_VALID. A START pulse during an L=4 pass -> no effect.
- Reset mid-pass: assert RST while in MULT2 of element 2 -> all outputs 0 the same cycle. A fresh START afterwards runs element 0 correctly.
